// File: rtl/fixed_exp_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_exp_sched_pkg                                                      |
// | Shared types and constants for the Q4.28 exponential scheduler:          |
// | Q4.28 unity, FSM state encoding and the 1/k! coefficient ROM.            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package fixed_exp_sched_pkg;

  // Q4.28 representation of 1.0
  localparam logic [31:0] c_one = 32'h1000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_SYNC = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // 1/k! in Q4.28, round-to-nearest; zero outside k=1..8
  function automatic logic [31:0] coef(input logic [3:0] k);
    case (k)
      4'd1:    coef = c_one;
      4'd2:    coef = 32'h0800_0000;
      4'd3:    coef = 32'h02AA_AAAB;
      4'd4:    coef = 32'h00AA_AAAB;
      4'd5:    coef = 32'h0022_2222;
      4'd6:    coef = 32'h0005_B05B;
      4'd7:    coef = 32'h0000_D00D;
      4'd8:    coef = 32'h0000_1A02;
      default: coef = 32'h0000_0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_exp_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_exp_sched_if                                                       |
// | Requester handshake plus datapath control bundle of the scheduler.       |
// | master = requesters/datapath side, slave = scheduler side.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface fixed_exp_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   arg;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 done;
  logic [31:0]          x_out;
  logic [31:0]          cf;
  logic                 m0;
  logic                 m1;
  logic                 res_m1;
  logic                 res_m2;
  logic                 res_a1;
  logic                 st;
  logic [3:0]           term_idx;

  modport master (
    output req, arg,
    input  gnt, busy, done, x_out, cf, m0, m1, res_m1, res_m2, res_a1, st, term_idx
  );

  modport slave (
    input  req, arg,
    output gnt, busy, done, x_out, cf, m0, m1, res_m1, res_m2, res_a1, st, term_idx
  );
endinterface
`default_nettype wire

// File: rtl/fixed_exp_sched_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_exp_sched_rr_arbiter                                               |
// | Combinational round-robin pick: first asserted request at or after the   |
// | pointer, returned as one-hot grant and encoded index.                    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fixed_exp_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  wire logic [NREQ-1:0] i_req,
  input  wire logic [IDXW-1:0] i_ptr,
  output logic      [NREQ-1:0] o_gnt,
  output logic      [IDXW-1:0] o_idx,
  output logic                 o_any
);

  localparam logic [IDXW:0] c_nreq = (IDXW+1)'(NREQ);

  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_cand;

  // Scan candidates pointer, pointer+1, ... modulo NREQ; first hit wins
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (IDXW+1)'(i);
      if (w_sum >= c_nreq) begin
        w_sum = w_sum - c_nreq;
      end
      w_cand = w_sum[IDXW-1:0];
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fixed_exp_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_exp_sched                                                          |
// | Round-robin scheduler/sequencer for the shared Q4.28 exponential         |
// | datapath: latches the winner's argument, steps the Taylor series term by |
// | term and drives mux selects, unit resets, 1/k! and the done pulse.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fixed_exp_sched
  import fixed_exp_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NTERMS  = 8,
  parameter int MUL_LAT = 2,
  parameter int ADD_LAT = 1
) (
  input wire logic         ck2,
  input wire logic         res,
  fixed_exp_sched_if.slave bus
);

  localparam int               IDXW       = $clog2(NREQ);
  localparam logic [3:0]       c_mul_last = 4'(MUL_LAT - 1);
  localparam logic [3:0]       c_add_last = 4'(ADD_LAT - 1);
  localparam logic [3:0]       c_nterms   = 4'(NTERMS);
  localparam logic [IDXW-1:0]  c_last_idx = IDXW'(NREQ - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_ptr;
  logic [IDXW-1:0]   r_win;
  logic [NREQ-1:0]   r_gnt;
  logic [31:0]       r_x;
  logic [3:0]        r_k;
  logic [3:0]        r_phase;
  logic [NREQ-1:0]   w_arb_gnt;
  logic [IDXW-1:0]   w_arb_idx;
  logic              w_arb_any;
  logic              w_phase_end;
  logic              w_series;

  fixed_exp_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_phase_end = (r_phase == 4'd0);
  assign w_series    = (r_state == S_MUL) || (r_state == S_ACC);
  assign bus.gnt     = r_gnt;
  assign bus.x_out   = r_x;

  // State register
  always_ff @(posedge ck2) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and decoded datapath controls; the units stay out of reset
  // from LOAD through DONE so the result is still valid when done pulses
  always_comb begin
    w_state_nxt  = r_state;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_DONE);
    bus.st       = (r_state == S_SYNC);
    bus.res_m1   = (r_state == S_IDLE);
    bus.res_m2   = (r_state == S_IDLE);
    bus.res_a1   = (r_state == S_IDLE);
    bus.term_idx = w_series ? r_k : 4'd0;
    bus.cf       = w_series ? coef(r_k) : 32'h0;
    bus.m1       = w_series;
    bus.m0       = w_series && (r_k > 4'd1);
    case (r_state)
      S_IDLE: if (w_arb_any) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_MUL;
      S_MUL:  if (w_phase_end) w_state_nxt = S_ACC;
      S_ACC:  if (w_phase_end) w_state_nxt = (r_k < c_nterms) ? S_MUL : S_SYNC;
      S_SYNC: w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant/argument capture, term and phase counters, round-robin pointer
  always_ff @(posedge ck2) begin
    if (res) begin
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_x     <= '0;
      r_k     <= 4'd0;
      r_phase <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arb_any) begin
            r_gnt <= w_arb_gnt;
            r_win <= w_arb_idx;
            r_x   <= bus.arg[{w_arb_idx, 5'd0} +: 32];
          end
        end
        S_LOAD: begin
          r_k     <= 4'd1;
          r_phase <= c_mul_last;
        end
        S_MUL: begin
          r_phase <= w_phase_end ? c_add_last : (r_phase - 4'd1);
        end
        S_ACC: begin
          if (w_phase_end) begin
            r_phase <= c_mul_last;
            if (r_k < c_nterms) begin
              r_k <= r_k + 4'd1;
            end
          end else begin
            r_phase <= r_phase - 4'd1;
          end
        end
        S_DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_win == c_last_idx) ? '0 : (r_win + 1'b1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_exp_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fixed_exp_sched                                                       |
// | Self-checking bench: default instance (NTERMS=8, MUL_LAT=2, ADD_LAT=1)   |
// | plus a minimal instance (NTERMS=1, MUL_LAT=1, ADD_LAT=1).                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_fixed_exp_sched;

  logic ck2 = 1'b0;
  logic res = 1'b1;
  always #5 ck2 = ~ck2;

  fixed_exp_sched_if #(.NREQ(4)) if_a ();
  fixed_exp_sched_if #(.NREQ(4)) if_b ();

  fixed_exp_sched #(.NREQ(4), .NTERMS(8), .MUL_LAT(2), .ADD_LAT(1)) u_dut_a (
    .ck2 (ck2), .res (res), .bus (if_a)
  );
  fixed_exp_sched #(.NREQ(4), .NTERMS(1), .MUL_LAT(1), .ADD_LAT(1)) u_dut_b (
    .ck2 (ck2), .res (res), .bus (if_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;   // reference round-robin pointer

  logic [3:0]  s_gnt;
  logic        s_busy, s_done, s_st, s_m0, s_m1;
  logic [2:0]  s_rst;
  logic [31:0] s_x, s_cf;
  logic [3:0]  s_term;

  task automatic tick();
    @(posedge ck2);
    #1;
  endtask

  task automatic snap(input bit use_b);
    if (use_b) begin
      s_gnt = if_b.gnt; s_busy = if_b.busy; s_done = if_b.done; s_st = if_b.st;
      s_x = if_b.x_out; s_cf = if_b.cf; s_m0 = if_b.m0; s_m1 = if_b.m1;
      s_rst = {if_b.res_m1, if_b.res_m2, if_b.res_a1}; s_term = if_b.term_idx;
    end else begin
      s_gnt = if_a.gnt; s_busy = if_a.busy; s_done = if_a.done; s_st = if_a.st;
      s_x = if_a.x_out; s_cf = if_a.cf; s_m0 = if_a.m0; s_m1 = if_a.m1;
      s_rst = {if_a.res_m1, if_a.res_m2, if_a.res_a1}; s_term = if_a.term_idx;
    end
  endtask

  // round(2^28 / k!) computed directly
  function automatic logic [31:0] coef_ref(input int k);
    longint f;
    f = 1;
    for (int i = 1; i <= k; i++) f = f * i;
    return 32'((64'd268435456 + f / 2) / f);
  endfunction

  function automatic logic [3:0] rr_pick(input logic [3:0] r, input int ptr);
    logic [3:0] g;
    g = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (g == 4'b0 && r[(ptr + i) % 4]) g[(ptr + i) % 4] = 1'b1;
    end
    return g;
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Follows one transaction from its LOAD cycle (t=0) through the IDLE
  // cycle after done, checking every cycle against the timeline
  // LOAD, NT*(ML MUL + AL ACC), SYNC, DONE, IDLE.
  task automatic follow(input bit use_b, input logic [3:0] exp_g, input logic [31:0] exp_x,
                        input int nt, input int ml, input int al, input int exp_wait,
                        input logic [3:0] rel_mask, input int drop_bit, input int drop_term);
    int p, tot, term, waited;
    bit in_series, in_mul;
    logic [3:0]  e_gnt;
    logic [2:0]  e_ctrl, e_rst;
    logic [31:0] e_cf;
    p = ml + al;
    tot = nt * p;
    waited = 0;
    snap(use_b);
    while (s_gnt == 4'b0 && waited < 40) begin
      tick(); snap(use_b); waited++;
    end
    n_tests++;
    if (s_gnt == 4'b0) begin
      n_fail++;
      $display("FAIL load_timeout: gnt=%b after %0d cycles, required a grant", s_gnt, waited);
      return;
    end
    if (exp_wait >= 0) begin
      n_tests++;
      if (waited != exp_wait) begin
        n_fail++;
        $display("FAIL idle_gap: %0d extra idle cycles, required %0d", waited, exp_wait);
      end
    end
    for (int t = 0; t <= tot + 3; t++) begin
      if (t > 0) begin tick(); snap(use_b); end
      in_series = (t >= 1) && (t <= tot);
      term      = in_series ? ((t - 1) / p) + 1 : 0;
      in_mul    = in_series && (((t - 1) % p) < ml);
      e_gnt     = (t <= tot + 2) ? exp_g : 4'b0;
      e_ctrl    = {(t <= tot + 2), (t == tot + 1), (t == tot + 2)};
      n_tests++;
      if (s_gnt !== e_gnt) begin
        n_fail++; $display("FAIL gnt t=%0d: got %b, required %b", t, s_gnt, e_gnt);
      end
      n_tests++;
      if ({s_busy, s_st, s_done} !== e_ctrl) begin
        n_fail++; $display("FAIL busy_st_done t=%0d: got %b, required %b", t, {s_busy, s_st, s_done}, e_ctrl);
      end
      n_tests++;
      if (s_term !== 4'(term)) begin
        n_fail++; $display("FAIL term_idx t=%0d: got %0d, required %0d", t, s_term, term);
      end
      if (t == 0) begin
        n_tests++;
        if (s_x !== exp_x) begin
          n_fail++; $display("FAIL x_out: got %h, required %h", s_x, exp_x);
        end
      end
      if (t >= 1) begin
        e_rst = (t == tot + 3) ? 3'b111 : 3'b000;
        n_tests++;
        if (s_rst !== e_rst) begin
          n_fail++; $display("FAIL unit_resets t=%0d: got %b, required %b", t, s_rst, e_rst);
        end
      end
      if (in_series || t == tot + 3) begin
        e_cf = in_series ? coef_ref(term) : 32'h0;
        n_tests++;
        if (s_cf !== e_cf) begin
          n_fail++; $display("FAIL cf t=%0d: got %h, required %h", t, s_cf, e_cf);
        end
      end
      if (in_mul) begin
        n_tests++;
        if ({s_m1, s_m0} !== {1'b1, (term > 1)}) begin
          n_fail++; $display("FAIL mux_sel t=%0d k=%0d: m1m0=%b, required %b", t, term, {s_m1, s_m0}, {1'b1, (term > 1)});
        end
      end
      if (nt == 1) begin
        n_tests++;
        if (s_m0 !== 1'b0) begin
          n_fail++; $display("FAIL m0_zero t=%0d: got %b, required 0", t, s_m0);
        end
      end
      if (drop_bit >= 0 && term == drop_term) begin
        if (use_b) if_b.req = if_b.req & ~(4'b1 << drop_bit);
        else       if_a.req = if_a.req & ~(4'b1 << drop_bit);
      end
      if (t == tot + 2) begin
        if (use_b) if_b.req = if_b.req & ~rel_mask;
        else       if_a.req = if_a.req & ~rel_mask;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    if_a.req = 4'b1111;
    if_b.req = 4'b1111;
    if_a.arg = {$urandom, $urandom, $urandom, $urandom};
    if_b.arg = {$urandom, $urandom, $urandom, $urandom};
    res = 1'b1;
    repeat (3) tick();
    snap(0);
    n_tests++;
    if ({s_gnt, s_busy, s_st, s_done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_gnt_busy: got %b, required 0000000", {s_gnt, s_busy, s_st, s_done});
    end
    n_tests++;
    if (s_rst !== 3'b111) begin
      n_fail++; $display("FAIL reset_unit_resets: got %b, required 111", s_rst);
    end
    n_tests++;
    if ({s_cf, s_term, s_m0, s_m1} !== 38'b0) begin
      n_fail++; $display("FAIL reset_cf_term: cf=%h term=%0d m0=%b m1=%b, required all 0", s_cf, s_term, s_m0, s_m1);
    end
    n_tests++;
    if (s_x !== 32'h0) begin
      n_fail++; $display("FAIL reset_x_out: got %h, required 0", s_x);
    end
    snap(1);
    n_tests++;
    if ({s_gnt, s_busy, s_rst} !== 8'b0000_0111) begin
      n_fail++; $display("FAIL reset_b: got %b, required 00000111", {s_gnt, s_busy, s_rst});
    end
    if_a.req = 4'b0;
    if_b.req = 4'b0;
    res = 1'b0;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    if_a.arg = {$urandom, $urandom, $urandom, $urandom};
    if_a.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = rr_pick(4'b1111, m_ptr);
      follow(0, g, if_a.arg[32 * oh_idx(g) +: 32], 8, 2, 1, (i == 0) ? -1 : 0,
             (i == 4) ? 4'b1111 : 4'b0000, -1, 0);
      m_ptr = (oh_idx(g) + 1) % 4;
    end
  endtask

  task automatic test_single();
    logic [3:0] g;
    if_a.arg = {$urandom, $urandom, 32'h0800_0000, $urandom};
    if_a.req = 4'b0010;
    g = rr_pick(4'b0010, m_ptr);
    follow(0, g, 32'h0800_0000, 8, 2, 1, -1, 4'b0010, -1, 0);
    m_ptr = (oh_idx(g) + 1) % 4;
  endtask

  task automatic test_drop();
    logic [3:0] g;
    if_a.arg = {$urandom, $urandom, $urandom, $urandom};
    if_a.req = 4'b0001;
    g = rr_pick(4'b0001, m_ptr);
    follow(0, g, if_a.arg[31:0], 8, 2, 1, -1, 4'b0000, 0, 3);
    m_ptr = (oh_idx(g) + 1) % 4;
    for (int i = 0; i < 5; i++) begin
      snap(0);
      n_tests++;
      if ({s_gnt, s_busy} !== 5'b0) begin
        n_fail++; $display("FAIL drop_regrant c=%0d: gnt=%b busy=%b, required 0", i, s_gnt, s_busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    int waited;
    if_a.arg = {$urandom, $urandom, $urandom, $urandom};
    if_a.req = 4'b0110;
    g = rr_pick(4'b0110, m_ptr);
    tick(); snap(0);
    waited = 0;
    while (s_gnt == 4'b0 && waited < 40) begin tick(); snap(0); waited++; end
    n_tests++;
    if (s_gnt !== g) begin
      n_fail++; $display("FAIL mid_grant: got %b, required %b", s_gnt, g);
    end
    waited = 0;
    while (s_term != 4'd5 && waited < 60) begin tick(); snap(0); waited++; end
    n_tests++;
    if (s_term !== 4'd5) begin
      n_fail++; $display("FAIL mid_term5: term_idx=%0d, required 5", s_term);
    end
    res = 1'b1;
    if_a.req = 4'b0;
    tick();
    res = 1'b0;
    snap(0);
    n_tests++;
    if ({s_gnt, s_busy, s_st, s_done, s_term, s_rst} !== 14'b0000_000_0000_111) begin
      n_fail++; $display("FAIL mid_abort: gnt=%b bsd=%b term=%0d rst=%b, required 0000 000 0 111",
                         s_gnt, {s_busy, s_st, s_done}, s_term, s_rst);
    end
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); snap(0);
      n_tests++;
      if ({s_busy, s_st, s_done} !== 3'b0) begin
        n_fail++; $display("FAIL mid_no_done c=%0d: got %b, required 000", i, {s_busy, s_st, s_done});
      end
    end
    if_a.req = 4'b0101;
    g = rr_pick(4'b0101, m_ptr);
    follow(0, g, if_a.arg[32 * oh_idx(g) +: 32], 8, 2, 1, -1, g, -1, 0);
    m_ptr = (oh_idx(g) + 1) % 4;
    g = rr_pick(4'b0100, m_ptr);
    follow(0, g, if_a.arg[32 * oh_idx(g) +: 32], 8, 2, 1, 0, g, -1, 0);
    m_ptr = (oh_idx(g) + 1) % 4;
  endtask

  task automatic test_random();
    logic [3:0] r, g;
    for (int i = 0; i < 6; i++) begin
      r = 4'($urandom_range(1, 15));
      if_a.arg = {$urandom, $urandom, $urandom, $urandom};
      if_a.req = r;
      g = rr_pick(r, m_ptr);
      follow(0, g, if_a.arg[32 * oh_idx(g) +: 32], 8, 2, 1, -1, 4'b1111, -1, 0);
      m_ptr = (oh_idx(g) + 1) % 4;
    end
  endtask

  task automatic test_param_sweep();
    logic [31:0] x;
    x = $urandom;
    if_b.arg = {$urandom, $urandom, $urandom, x};
    if_b.req = 4'b0001;
    follow(1, 4'b0001, x, 1, 1, 1, -1, 4'b0001, -1, 0);
  endtask

  initial begin
    if_a.req = 4'b0;
    if_b.req = 4'b0;
    if_a.arg = '0;
    if_b.arg = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_drop();
    test_reset_mid();
    test_random();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, required finish before 500000", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule
`default_nettype wire
